// File: rtl/midi_pkg.sv
// Shared MIDI definitions: link rate, default system clock, receiver state
// encodings and the status nibbles that the message processor decodes.
package midi_pkg;

    localparam int MIDI_BAUD  = 31250;
    localparam int SYS_CLK_HZ = 50000000;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_e;

    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [3:0] CTRL_CHANGE = 4'hB;

endpackage

// File: rtl/midi_uart_rx_if.sv
// Byte-level output of the MIDI receiver: one-cycle strobes plus the held
// byte value, consumed by the MIDI message processor.
interface midi_uart_rx_if;

    logic       isByteAvailable;
    logic [7:0] byteValue;
    logic       framingError;

    modport master (
        output isByteAvailable,
        output byteValue,
        output framingError
    );

    modport slave (
        input isByteAvailable,
        input byteValue,
        input framingError
    );

endinterface

// File: rtl/midi_rx_sync.sv
// Two-flop synchroniser for the asynchronous MIDI line; resets to the
// idle level so a reset never looks like a start edge.
module midi_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver (8N1, LSB first) with mid-bit sampling, start-glitch
// rejection, framing-error pulse and break recovery.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_IDLE | after reset or framing error; wait for the line to go high
// IDLE      | line high, waiting for a start edge
// START     | half-bit wait, then confirm start bit is still low
// DATA      | one bit period per data bit, sample at terminal count
// STOP      | one bit period, sample stop bit, emit byte or framing error
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = SYS_CLK_HZ,
    parameter int BAUD   = MIDI_BAUD
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            MIDI_RX,
    midi_uart_rx_if.master  rx_bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_WAIT_IDLE = 3'(WAIT_IDLE);
    localparam logic [2:0] S_IDLE      = 3'(IDLE);
    localparam logic [2:0] S_START     = 3'(START);
    localparam logic [2:0] S_DATA      = 3'(DATA);
    localparam logic [2:0] S_STOP      = 3'(STOP);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("midi_uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    byte_q;
    logic          avail_q;
    logic          ferr_q;

    midi_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .d     (MIDI_RX),
        .q     (rx_s)
    );

    // Every terminal count clears cnt, so it never wraps inside a state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            byte_q  <= '0;
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_TC) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt <= '0;
                        if (rx_s) begin
                            byte_q  <= shift;
                            avail_q <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            // Low stop bit: likely a break, so wait for the line to recover.
                            ferr_q <= 1'b1;
                            state  <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_WAIT_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.isByteAvailable = avail_q;
    assign rx_bus.byteValue       = byte_q;
    assign rx_bus.framingError    = ferr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at 100 clocks per bit (scaled clock so the
// whole sequence stays short); expected values are hand-derived constants.
module tb_midi_uart_rx;
    import midi_pkg::*;

    localparam int CLK_HZ = 3125000;
    localparam int BAUD   = 31250;
    localparam int CPB    = 100;
    localparam int HALF   = 50;
    // line drive -> strobe visible: 2 sync cycles + HALF + 9*CPB + 1
    localparam int LAT    = 2 + HALF + 9 * CPB + 1;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    logic MIDI_RX  = 1'b1;

    midi_uart_rx_if bus ();

    midi_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .MIDI_RX  (MIDI_RX),
        .rx_bus   (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int         n_byte = 0;
    int         n_fe   = 0;
    int         n_both = 0;
    int         n_long = 0;
    int         byte_cyc[$];
    logic [7:0] byte_log[$];
    logic       prev_av = 1'b0;
    logic       prev_fe = 1'b0;

    always @(negedge CLOCK_50) begin
        if (bus.isByteAvailable) begin
            n_byte++;
            byte_cyc.push_back(cyc);
            byte_log.push_back(bus.byteValue);
        end
        if (bus.framingError) n_fe++;
        if (bus.isByteAvailable && bus.framingError) n_both++;
        if ((bus.isByteAvailable && prev_av) || (bus.framingError && prev_fe)) n_long++;
        prev_av = bus.isByteAvailable;
        prev_fe = bus.framingError;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bitdrv(input logic v, input int n);
        MIDI_RX = v;
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    int f_start;

    task automatic send(input logic [7:0] b, input int cpb, input logic stop_v);
        f_start = cyc;
        bitdrv(1'b0, cpb);
        for (int i = 0; i < 8; i++) bitdrv(b[i], cpb);
        bitdrv(stop_v, cpb);
    endtask

    int s0;
    int f0;

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_avail", 32'(bus.isByteAvailable), 32'h0);
        chk("rst_byte",  32'(bus.byteValue),       32'h00);
        chk("rst_ferr",  32'(bus.framingError),    32'h0);
        RESET_N = 1'b1;
        bitdrv(1'b1, 20);

        // Single note-on status byte at nominal rate
        send({NOTE_ON, 4'h0}, CPB, 1'b1);
        bitdrv(1'b1, 5);
        chk("f1_count", n_byte, 1);
        chk("f1_value", 32'(byte_log[0]), 32'h90);
        chk("f1_hold",  32'(bus.byteValue), 32'h90);
        chk("f1_fe",    n_fe, 0);
        chk("f1_lat",   byte_cyc[0] - f_start, LAT);

        // Three frames with no idle gap
        s0 = n_byte;
        send(8'h90, CPB, 1'b1);
        send(8'h3C, CPB, 1'b1);
        send(8'h64, CPB, 1'b1);
        bitdrv(1'b1, 5);
        chk("b2b_count", n_byte, s0 + 3);
        chk("b2b_v0",    32'(byte_log[s0]),     32'h90);
        chk("b2b_v1",    32'(byte_log[s0 + 1]), 32'h3C);
        chk("b2b_v2",    32'(byte_log[s0 + 2]), 32'h64);
        chk("b2b_gap1",  byte_cyc[s0 + 1] - byte_cyc[s0],     10 * CPB);
        chk("b2b_gap2",  byte_cyc[s0 + 2] - byte_cyc[s0 + 1], 10 * CPB);

        // Short low glitch shorter than half a bit
        s0 = n_byte;
        f0 = n_fe;
        bitdrv(1'b0, 25);
        bitdrv(1'b1, 200);
        chk("gl_bytes", n_byte, s0);
        chk("gl_fe",    n_fe, f0);
        chk("gl_hold",  32'(bus.byteValue), 32'h64);
        send(8'h45, CPB, 1'b1);
        bitdrv(1'b1, 5);
        chk("gl_next_cnt", n_byte, s0 + 1);
        chk("gl_next_val", 32'(byte_log[s0]), 32'h45);

        // Low stop bit followed by a held-low break
        s0 = n_byte;
        f0 = n_fe;
        send(8'h3C, CPB, 1'b0);
        bitdrv(1'b0, 3000);
        bitdrv(1'b1, 300);
        chk("fe_count", n_fe, f0 + 1);
        chk("fe_bytes", n_byte, s0);
        chk("fe_hold",  32'(bus.byteValue), 32'h45);
        send(8'h7F, CPB, 1'b1);
        bitdrv(1'b1, 5);
        chk("fe_next_cnt", n_byte, s0 + 1);
        chk("fe_next_val", 32'(byte_log[s0]), 32'h7F);

        // Reset during data bit 4 of 0x90, line low at release
        s0 = n_byte;
        f0 = n_fe;
        bitdrv(1'b0, CPB);
        bitdrv(1'b0, 4 * CPB);
        bitdrv(1'b1, HALF);
        RESET_N = 1'b0;
        MIDI_RX = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        chk("mr_rst_byte", 32'(bus.byteValue), 32'h00);
        RESET_N = 1'b1;
        bitdrv(1'b0, 20);
        bitdrv(1'b1, 1200);
        chk("mr_bytes", n_byte, s0);
        chk("mr_fe",    n_fe, f0);
        chk("mr_hold",  32'(bus.byteValue), 32'h00);
        send({NOTE_OFF, 4'h0}, CPB, 1'b1);
        bitdrv(1'b1, 5);
        chk("mr_next_cnt", n_byte, s0 + 1);
        chk("mr_next_val", 32'(bus.byteValue), 32'h80);

        // Transmitter rate at -3% and +3%
        for (int k = 0; k < 2; k++) begin
            int cpb_k;
            cpb_k = (k == 0) ? 97 : 103;
            s0 = n_byte;
            f0 = n_fe;
            send(8'h55, cpb_k, 1'b1);
            bitdrv(1'b1, 50);
            send(8'hAA, cpb_k, 1'b1);
            bitdrv(1'b1, 50);
            chk("tol_count", n_byte, s0 + 2);
            chk("tol_v55",   32'(byte_log[s0]),     32'h55);
            chk("tol_vaa",   32'(byte_log[s0 + 1]), 32'hAA);
            chk("tol_fe",    n_fe, f0);
        end

        chk("both_high", n_both, 0);
        chk("long_strobe", n_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
